// File: rtl/seq_core_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seq_core_hazard_ctrl_pkg
// Shared types and constants for the seq_core pipeline hazard controller.
//   hc_state_e : controller FSM encoding (HC_RUN, HC_FLUSH, HC_DRAIN, HC_HALTED)
//   PEND_W     : width of each per-register pending-write counter
//   src_hazard : helper folding "source used", "register busy" and
//                "bypass can satisfy it" into a single RAW hazard bit
// -----------------------------------------------------------------------------
package seq_core_hazard_ctrl_pkg;

  localparam int PEND_W = 2;

  typedef enum logic [1:0] {
    HC_RUN    = 2'd0,
    HC_FLUSH  = 2'd1,
    HC_DRAIN  = 2'd2,
    HC_HALTED = 2'd3
  } hc_state_e;

  // A source is a hazard when it is read, has an outstanding write and the
  // writeback bypass cannot deliver the value this cycle.
  function automatic logic src_hazard(input logic use_src,
                                      input logic busy,
                                      input logic fwd_ok);
    return use_src & busy & ~fwd_ok;
  endfunction

endpackage

// File: rtl/seq_core_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// seq_core_hazard_ctrl_if
// Bundle between the seq_core datapath and the hazard controller.
//   Read stage : rd_valid, rd_src1/_use, rd_src2/_use, rd_dst/_we, rd_is_halt
//   Execute    : ex_branch_taken, ex_mem_busy
//   Writeback  : wb_valid, wb_dst
//   Control    : issue, stall_fetch, stall_read, flush, halted, busy_regs, sb_err
// modport master : the datapath side (drives stage status, receives control)
// modport slave  : the hazard controller
// -----------------------------------------------------------------------------
interface seq_core_hazard_ctrl_if #(
  parameter int NR_REGS = 8,
  parameter int R_SIZE  = 3
);
  logic              rd_valid;
  logic [R_SIZE-1:0] rd_src1;
  logic              rd_src1_use;
  logic [R_SIZE-1:0] rd_src2;
  logic              rd_src2_use;
  logic [R_SIZE-1:0] rd_dst;
  logic              rd_dst_we;
  logic              rd_is_halt;
  logic              ex_branch_taken;
  logic              ex_mem_busy;
  logic              wb_valid;
  logic [R_SIZE-1:0] wb_dst;

  logic              issue;
  logic              stall_fetch;
  logic              stall_read;
  logic              flush;
  logic              halted;
  logic [NR_REGS-1:0] busy_regs;
  logic              sb_err;

  modport master (
    output rd_valid, rd_src1, rd_src1_use, rd_src2, rd_src2_use,
           rd_dst, rd_dst_we, rd_is_halt, ex_branch_taken, ex_mem_busy,
           wb_valid, wb_dst,
    input  issue, stall_fetch, stall_read, flush, halted, busy_regs, sb_err
  );

  modport slave (
    input  rd_valid, rd_src1, rd_src1_use, rd_src2, rd_src2_use,
           rd_dst, rd_dst_we, rd_is_halt, ex_branch_taken, ex_mem_busy,
           wb_valid, wb_dst,
    output issue, stall_fetch, stall_read, flush, halted, busy_regs, sb_err
  );
endinterface

// File: rtl/seq_core_scoreboard.sv
// -----------------------------------------------------------------------------
// seq_core_scoreboard
// Per-register pending-write counters for seq_core.
//   clk, rst_n     : clock, asynchronous active-low reset
//   inc_en/inc_idx : an instruction writing inc_idx issues this cycle
//   dec_en/dec_idx : writeback commits dec_idx this cycle
//   busy_regs      : bit i = pending[i] != 0
//   pend_max_vec   : bit i = pending[i] == PEND_MAX (no further writes allowed)
//   pend_one_vec   : bit i = pending[i] == 1 (single write outstanding)
//   sb_err         : sticky, writeback seen for a register with nothing pending
// -----------------------------------------------------------------------------
module seq_core_scoreboard
  import seq_core_hazard_ctrl_pkg::*;
#(
  parameter int NR_REGS  = 8,
  parameter int R_SIZE   = 3,
  parameter int PEND_MAX = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc_en,
  input  logic [R_SIZE-1:0]  inc_idx,
  input  logic               dec_en,
  input  logic [R_SIZE-1:0]  dec_idx,
  output logic [NR_REGS-1:0] busy_regs,
  output logic [NR_REGS-1:0] pend_max_vec,
  output logic [NR_REGS-1:0] pend_one_vec,
  output logic               sb_err
);

  logic [NR_REGS-1:0] underflow;
  logic               sb_err_reg;

  generate
    for (genvar gi = 0; gi < NR_REGS; gi++) begin : g_cnt
      logic              inc_hit;
      logic              dec_hit;
      logic [PEND_W-1:0] pending_reg;

      assign inc_hit = inc_en && (inc_idx == R_SIZE'(gi));
      assign dec_hit = dec_en && (dec_idx == R_SIZE'(gi));

      assign busy_regs[gi]    = (pending_reg != '0);
      assign pend_max_vec[gi] = (pending_reg == PEND_W'(PEND_MAX));
      assign pend_one_vec[gi] = (pending_reg == PEND_W'(1));

      // A same-cycle issue and writeback on one register cancel out, so only
      // a lone writeback against an empty counter is an error.
      assign underflow[gi] = dec_hit && !inc_hit && (pending_reg == '0);

      // Counter saturates at both ends; the hazard logic never issues a write
      // to a register already at PEND_MAX, the clamp just keeps it safe.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pending_reg <= '0;
        end else if (inc_hit && !dec_hit) begin
          if (pending_reg != PEND_W'(PEND_MAX))
            pending_reg <= pending_reg + 1'b1;
        end else if (dec_hit && !inc_hit) begin
          if (pending_reg != '0)
            pending_reg <= pending_reg - 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sb_err_reg <= 1'b0;
    else if (|underflow)
      sb_err_reg <= 1'b1;
  end

  assign sb_err = sb_err_reg;

endmodule

// File: rtl/seq_core_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// seq_core_hazard_ctrl
// Pipeline control for the 3-stage seq_core (fetch -> read -> execute/wb).
// Detects RAW / write-overflow hazards against the pending-write scoreboard,
// flushes after taken branches, holds issue while memory is busy and drains
// the pipeline before halting on HALT.
//   clk, rst_n : clock, asynchronous active-low reset
//   hc (slave) : read-stage instruction info, execute/writeback status in;
//                issue, stall_fetch, stall_read, flush, halted, busy_regs,
//                sb_err out
// Build option: define SEQ_CORE_FORWARD_EN to let a source satisfied by the
// writeback bypass in the same cycle issue without a stall.
// -----------------------------------------------------------------------------
module seq_core_hazard_ctrl
  import seq_core_hazard_ctrl_pkg::*;
#(
  parameter int NR_REGS      = 8,
  parameter int R_SIZE       = 3,
  parameter int PEND_MAX     = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  seq_core_hazard_ctrl_if.slave hc
);

`ifdef SEQ_CORE_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  hc_state_e          state_reg, state_next;
  logic [1:0]         flush_cnt_reg, flush_cnt_next;

  logic [NR_REGS-1:0] busy_vec;
  logic [NR_REGS-1:0] max_vec;
  logic [NR_REGS-1:0] one_vec;
  logic               sb_err_w;

  logic               fwd1, fwd2;
  logic               hazard;
  logic               issue_w, stall_w, flush_w, halted_w;

  seq_core_scoreboard #(
    .NR_REGS  (NR_REGS),
    .R_SIZE   (R_SIZE),
    .PEND_MAX (PEND_MAX)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc_en       (issue_w & hc.rd_dst_we),
    .inc_idx      (hc.rd_dst),
    .dec_en       (hc.wb_valid),
    .dec_idx      (hc.wb_dst),
    .busy_regs    (busy_vec),
    .pend_max_vec (max_vec),
    .pend_one_vec (one_vec),
    .sb_err       (sb_err_w)
  );

  // Bypass only covers the last outstanding write: with two in flight the
  // committing value is not the one the reader needs.
  assign fwd1 = FWD_EN && hc.wb_valid && (hc.wb_dst == hc.rd_src1) && one_vec[hc.rd_src1];
  assign fwd2 = FWD_EN && hc.wb_valid && (hc.wb_dst == hc.rd_src2) && one_vec[hc.rd_src2];

  assign hazard = src_hazard(hc.rd_src1_use, busy_vec[hc.rd_src1], fwd1)
                | src_hazard(hc.rd_src2_use, busy_vec[hc.rd_src2], fwd2)
                | (hc.rd_dst_we & max_vec[hc.rd_dst]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= HC_RUN;
      flush_cnt_reg <= 2'd0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  // The branch cycle itself is the first flush cycle (flush asserted
  // combinationally in RUN); HC_FLUSH covers the remaining FLUSH_CYCLES-1.
  // flush_cnt holds the number of flush cycles already spent.
  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    issue_w        = 1'b0;
    stall_w        = 1'b0;
    flush_w        = 1'b0;
    halted_w       = 1'b0;

    case (state_reg)
      HC_RUN: begin
        flush_w = hc.ex_branch_taken;
        issue_w = hc.rd_valid & ~hazard & ~hc.ex_mem_busy & ~hc.ex_branch_taken;
        stall_w = hc.rd_valid & ~issue_w & ~hc.ex_branch_taken;
        if (hc.ex_branch_taken) begin
          if (FLUSH_CYCLES > 1) begin
            state_next     = HC_FLUSH;
            flush_cnt_next = 2'd1;
          end
        end else if (issue_w && hc.rd_is_halt) begin
          state_next = HC_DRAIN;
        end
      end

      HC_FLUSH: begin
        flush_w = 1'b1;
        if (hc.ex_branch_taken) begin
          flush_cnt_next = 2'd1;
        end else if (int'(flush_cnt_reg) + 1 >= FLUSH_CYCLES) begin
          state_next     = HC_RUN;
          flush_cnt_next = 2'd0;
        end else begin
          flush_cnt_next = flush_cnt_reg + 2'd1;
        end
      end

      // Branches here squash the front end but cannot redirect the core:
      // the HALT has already issued.
      HC_DRAIN: begin
        stall_w = 1'b1;
        flush_w = hc.ex_branch_taken;
        if (busy_vec == '0)
          state_next = HC_HALTED;
      end

      HC_HALTED: begin
        stall_w  = 1'b1;
        halted_w = 1'b1;
      end

      default: begin
        state_next = HC_RUN;
      end
    endcase
  end

  // rst_n gates the decoded controls so the pipeline sees all-quiet the
  // moment reset asserts, regardless of what the read stage presents.
  assign hc.issue       = rst_n & issue_w;
  assign hc.stall_fetch = rst_n & stall_w;
  assign hc.stall_read  = rst_n & stall_w;
  assign hc.flush       = rst_n & flush_w;
  assign hc.halted      = rst_n & halted_w;
  assign hc.busy_regs   = busy_vec;
  assign hc.sb_err      = sb_err_w;

endmodule

// File: tb/tb_seq_core_hazard_ctrl.sv
module tb_seq_core_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [2:0] s1;
    logic       u1;
    logic [2:0] s2;
    logic       u2;
    logic [2:0] d;
    logic       we;
    logic       halt;
    logic       br;
    logic       mb;
    logic       wv;
    logic [2:0] wd;
  } stim_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Expected output vectors, layout {issue, stall_fetch, stall_read, flush,
  // halted, sb_err, busy_regs[7:0]}.
  logic [13:0] exp_q[$];

  seq_core_hazard_ctrl_if #(.NR_REGS(8), .R_SIZE(3)) bus ();

  seq_core_hazard_ctrl #(
    .NR_REGS      (8),
    .R_SIZE       (3),
    .PEND_MAX     (2),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hc    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "timeout");
  end

  function automatic stim_t st(input logic v, input logic [2:0] s1, input logic u1,
                               input logic [2:0] s2, input logic u2,
                               input logic [2:0] d, input logic we, input logic halt,
                               input logic br, input logic mb,
                               input logic wv, input logic [2:0] wd);
    stim_t s;
    s = '{v:v, s1:s1, u1:u1, s2:s2, u2:u2, d:d, we:we, halt:halt, br:br, mb:mb, wv:wv, wd:wd};
    return s;
  endfunction

  function automatic stim_t idle();
    return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [13:0] ex(input logic iss, input logic stl, input logic fl,
                                     input logic hlt, input logic se, input logic [7:0] busy);
    return {iss, stl, stl, fl, hlt, se, busy};
  endfunction

  function automatic logic [13:0] obs();
    return {bus.issue, bus.stall_fetch, bus.stall_read, bus.flush, bus.halted,
            bus.sb_err, bus.busy_regs};
  endfunction

  task automatic apply(input stim_t s);
    bus.rd_valid        = s.v;
    bus.rd_src1         = s.s1;
    bus.rd_src1_use     = s.u1;
    bus.rd_src2         = s.s2;
    bus.rd_src2_use     = s.u2;
    bus.rd_dst          = s.d;
    bus.rd_dst_we       = s.we;
    bus.rd_is_halt      = s.halt;
    bus.ex_branch_taken = s.br;
    bus.ex_mem_busy     = s.mb;
    bus.wb_valid        = s.wv;
    bus.wb_dst          = s.wd;
  endtask

  task automatic test_reset();
    logic [13:0] want;
    logic [13:0] got;
    rst_n = 1'b0;
    apply(st(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    exp_q.push_back(ex(0, 0, 0, 0, 0, 8'h00));
    @(negedge clk);
    want = exp_q.pop_front(); got = obs(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_hold: got %b want %b", got, want);
    end
    apply(idle());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(ex(0, 0, 0, 0, 0, 8'h00));
    @(negedge clk);
    want = exp_q.pop_front(); got = obs(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", got, want);
    end
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_raw();
    stim_t s[$];
    logic [13:0] e[$];
    logic [13:0] want;
    logic [13:0] got;
    s.push_back(st(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0)); e.push_back(ex(1, 0, 0, 0, 0, 8'h00));
    s.push_back(st(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0)); e.push_back(ex(0, 1, 0, 0, 0, 8'h08));
`ifdef SEQ_CORE_FORWARD_EN
    s.push_back(st(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 1, 3)); e.push_back(ex(1, 0, 0, 0, 0, 8'h08));
    s.push_back(idle());                                  e.push_back(ex(0, 0, 0, 0, 0, 8'h10));
`else
    s.push_back(st(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 1, 3)); e.push_back(ex(0, 1, 0, 0, 0, 8'h08));
    s.push_back(st(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0)); e.push_back(ex(1, 0, 0, 0, 0, 8'h00));
`endif
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4)); e.push_back(ex(0, 0, 0, 0, 0, 8'h10));
    s.push_back(idle());                                  e.push_back(ex(0, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      want = exp_q.pop_front(); got = obs(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL raw[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
    $display("test_raw done: %0d cycles", s.size());
  endtask

  task automatic test_pend_max();
    stim_t s[$];
    logic [13:0] e[$];
    logic [13:0] want;
    logic [13:0] got;
    s.push_back(st(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0)); e.push_back(ex(1, 0, 0, 0, 0, 8'h00));
    s.push_back(st(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0)); e.push_back(ex(1, 0, 0, 0, 0, 8'h20));
    s.push_back(st(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0)); e.push_back(ex(0, 1, 0, 0, 0, 8'h20));
    s.push_back(st(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 5)); e.push_back(ex(0, 1, 0, 0, 0, 8'h20));
    s.push_back(st(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0)); e.push_back(ex(1, 0, 0, 0, 0, 8'h20));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5)); e.push_back(ex(0, 0, 0, 0, 0, 8'h20));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5)); e.push_back(ex(0, 0, 0, 0, 0, 8'h20));
    s.push_back(idle());                                  e.push_back(ex(0, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      want = exp_q.pop_front(); got = obs(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pend_max[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
    $display("test_pend_max done: %0d cycles", s.size());
  endtask

  task automatic test_branch();
    stim_t s[$];
    logic [13:0] e[$];
    logic [13:0] want;
    logic [13:0] got;
    s.push_back(st(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0)); e.push_back(ex(1, 0, 0, 0, 0, 8'h00));
    s.push_back(st(1, 2, 1, 0, 0, 6, 1, 0, 1, 0, 0, 0)); e.push_back(ex(0, 0, 1, 0, 0, 8'h04));
    s.push_back(st(1, 2, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0)); e.push_back(ex(0, 0, 1, 0, 0, 8'h04));
    s.push_back(st(1, 2, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0)); e.push_back(ex(0, 1, 0, 0, 0, 8'h04));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2)); e.push_back(ex(0, 0, 0, 0, 0, 8'h04));
    s.push_back(idle());                                  e.push_back(ex(0, 0, 0, 0, 0, 8'h00));
    s.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0)); e.push_back(ex(0, 0, 1, 0, 0, 8'h00));
    s.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(0, 0, 1, 0, 0, 8'h00));
    s.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(0, 1, 0, 0, 0, 8'h00));
    s.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ex(1, 0, 0, 0, 0, 8'h00));
    s.push_back(idle());                                  e.push_back(ex(0, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      want = exp_q.pop_front(); got = obs(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL branch[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
    $display("test_branch done: %0d cycles", s.size());
  endtask

  task automatic test_sb_err();
    stim_t s[$];
    logic [13:0] e[$];
    logic [13:0] want;
    logic [13:0] got;
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7)); e.push_back(ex(0, 0, 0, 0, 0, 8'h00));
    s.push_back(idle());                                  e.push_back(ex(0, 0, 0, 0, 1, 8'h00));
    s.push_back(st(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0)); e.push_back(ex(1, 0, 0, 0, 1, 8'h00));
    s.push_back(idle());                                  e.push_back(ex(0, 0, 0, 0, 1, 8'h80));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7)); e.push_back(ex(0, 0, 0, 0, 1, 8'h80));
    s.push_back(idle());                                  e.push_back(ex(0, 0, 0, 0, 1, 8'h00));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      want = exp_q.pop_front(); got = obs(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL sb_err[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
    $display("test_sb_err done: %0d cycles", s.size());
  endtask

  // sb_err is still set from test_sb_err, so every expectation carries it.
  task automatic test_halt();
    stim_t s[$];
    logic [13:0] e[$];
    logic [13:0] want;
    logic [13:0] got;
    s.push_back(st(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0)); e.push_back(ex(1, 0, 0, 0, 1, 8'h00));
    s.push_back(st(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); e.push_back(ex(1, 0, 0, 0, 1, 8'h02));
    s.push_back(idle());                                  e.push_back(ex(0, 1, 0, 0, 1, 8'h02));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); e.push_back(ex(0, 1, 0, 0, 1, 8'h02));
    s.push_back(idle());                                  e.push_back(ex(0, 1, 0, 0, 1, 8'h00));
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0)
        s.push_back(st(1, 1, 1, 0, 0, 2, 1, 0, 1, 0, 0, 0));
      else
        s.push_back(st(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 3'(k)));
      e.push_back(ex(0, 1, 0, 1, 1, 8'h00));
    end
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      want = exp_q.pop_front(); got = obs(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL halt[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
    $display("test_halt done: %0d cycles", s.size());
  endtask

  task automatic test_async_reset();
    stim_t s[$];
    logic [13:0] e[$];
    logic [13:0] want;
    logic [13:0] got;
    // Leave HALTED through a reset first.
    apply(idle());
    rst_n = 1'b0;
    exp_q.push_back(ex(0, 0, 0, 0, 0, 8'h00));
    #1;
    want = exp_q.pop_front(); got = obs(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL areset_from_halted: got %b want %b", got, want);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Enter DRAIN with r1 still pending.
    s.push_back(st(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0)); e.push_back(ex(1, 0, 0, 0, 0, 8'h00));
    s.push_back(st(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); e.push_back(ex(1, 0, 0, 0, 0, 8'h02));
    s.push_back(idle());                                  e.push_back(ex(0, 1, 0, 0, 0, 8'h02));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      want = exp_q.pop_front(); got = obs(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL areset_setup[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
    // Mid-cycle reset pulse with an issuable instruction on the read stage.
    #2;
    apply(st(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    exp_q.push_back(ex(0, 0, 0, 0, 0, 8'h00));
    #1;
    want = exp_q.pop_front(); got = obs(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL areset_immediate: got %b want %b", got, want);
    end
    @(posedge clk); #1;
    exp_q.push_back(ex(0, 0, 0, 0, 0, 8'h00));
    want = exp_q.pop_front(); got = obs(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL areset_held: got %b want %b", got, want);
    end
    apply(idle());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Back in RUN with a clean scoreboard: a write issues at once.
    apply(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    exp_q.push_back(ex(1, 0, 0, 0, 0, 8'h00));
    @(negedge clk);
    want = exp_q.pop_front(); got = obs(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL areset_run_issue: got %b want %b", got, want);
    end
    @(posedge clk); #1;
    apply(idle());
    exp_q.push_back(ex(0, 0, 0, 0, 0, 8'h01));
    @(negedge clk);
    want = exp_q.pop_front(); got = obs(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL areset_run_busy: got %b want %b", got, want);
    end
    @(posedge clk); #1;
    $display("test_async_reset done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    apply(idle());
    test_reset();
    test_raw();
    test_pend_max();
    test_branch();
    test_sb_err();
    test_halt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
